// File: rtl/control_unit.sv
// Fetch-decode-execute sequencer for the 32-bit accumulator ALU.
// Registers state, pc and ir; every control output is decoded combinationally from them.
module control_unit #(
  parameter int PC_W    = 8,
  parameter int DADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        iram_data,
  input  logic               z,
  input  logic               dram_ready,
  output logic [PC_W-1:0]    iram_addr,
  output logic [7:0]         alu_instruction,
  output logic [2:0]         bus_sel,
  output logic [3:0]         reg_we,
  output logic               dram_rd,
  output logic               dram_wr,
  output logic [DADDR_W-1:0] dram_addr,
  output logic               halted
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT} state_t;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_CLAC  = 8'h01;
  localparam logic [7:0] OP_INCAC = 8'h02;
  localparam logic [7:0] OP_DECAC = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h04;
  localparam logic [7:0] OP_SUB   = 8'h05;
  localparam logic [7:0] OP_MUL2  = 8'h06;
  localparam logic [7:0] OP_MUL4  = 8'h07;
  localparam logic [7:0] OP_DIV16 = 8'h08;
  localparam logic [7:0] OP_LDAC  = 8'h09;
  localparam logic [7:0] OP_STAC  = 8'h0A;
  localparam logic [7:0] OP_MVAC  = 8'h0B;
  localparam logic [7:0] OP_MOVR  = 8'h0C;
  localparam logic [7:0] OP_JMP   = 8'h0D;
  localparam logic [7:0] OP_JMPZ  = 8'h0E;
  localparam logic [7:0] OP_JMPNZ = 8'h0F;
  localparam logic [7:0] OP_END   = 8'hFF;

  localparam logic [7:0] ALU_HOLD = 8'd9;

  state_t          state, next_state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [7:0]      opcode;
  logic [7:0]      imm;
  logic [2:0]      reg_bus;
  logic            jump;

  assign opcode    = ir[15:8];
  assign imm       = ir[7:0];
  assign reg_bus   = {1'b0, imm[1:0]} + 3'd1;
  assign iram_addr = pc;
  assign halted    = (state == HALT);

  // A jump can only happen in EXEC, so it never collides with the DECODE increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        ir <= iram_data;
        pc <= pc + PC_W'(1);
      end else if (jump) begin
        pc <= PC_W'(imm);
      end
    end
  end

  always_comb begin
    next_state      = state;
    alu_instruction = ALU_HOLD;
    bus_sel         = 3'd0;
    reg_we          = 4'b0000;
    dram_rd         = 1'b0;
    dram_wr         = 1'b0;
    dram_addr       = '0;
    jump            = 1'b0;
    case (state)
      IDLE:   if (start) next_state = FETCH;
      FETCH:  next_state = DECODE;
      DECODE: next_state = EXEC;
      EXEC: begin
        next_state = FETCH;
        case (opcode)
          OP_CLAC:  alu_instruction = 8'd0;
          OP_INCAC: alu_instruction = 8'd1;
          OP_DECAC: alu_instruction = 8'd2;
          OP_ADD:   begin alu_instruction = 8'd3; bus_sel = reg_bus; end
          OP_SUB:   begin alu_instruction = 8'd4; bus_sel = reg_bus; end
          OP_MUL2:  alu_instruction = 8'd5;
          OP_MUL4:  alu_instruction = 8'd6;
          OP_DIV16: alu_instruction = 8'd7;
          OP_LDAC: begin
            dram_rd    = 1'b1;
            dram_addr  = DADDR_W'(imm);
            next_state = MEM;
          end
          OP_STAC: begin
            dram_wr    = 1'b1;
            dram_addr  = DADDR_W'(imm);
            next_state = MEM;
          end
          OP_MVAC:  reg_we = 4'b0001 << imm[1:0];
          OP_MOVR:  begin alu_instruction = 8'd8; bus_sel = reg_bus; end
          OP_JMP:   jump = 1'b1;
          OP_JMPZ:  jump = z;
          OP_JMPNZ: jump = ~z;
          OP_END:   next_state = HALT;
          default:  ;
        endcase
      end
      // The load result is moved into A only in the cycle the memory reports ready.
      MEM: begin
        dram_addr = DADDR_W'(imm);
        if (opcode == OP_LDAC) begin
          dram_rd = 1'b1;
          if (dram_ready) begin
            alu_instruction = 8'd8;
            bus_sel         = 3'd5;
          end
        end else begin
          dram_wr = 1'b1;
        end
        if (dram_ready) next_state = FETCH;
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

endmodule
